// File: rtl/binary_to_bcd.sv
// Sequential binary-to-BCD converter using the shift-add-3 (double dabble)
// algorithm. One bit is shifted per pass. Between shifts, each BCD digit is
// visited and adjusted, which keeps the datapath to a single 4-bit adder.
`timescale 1ns/1ps

module binary_to_bcd #(
  parameter int INPUT_WIDTH    = 8,
  parameter int DECIMAL_DIGITS = 2
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic [INPUT_WIDTH-1:0]        i_Binary,
  input  logic                          i_Start,
  output logic [4*DECIMAL_DIGITS-1:0]   o_BCD,
  output logic                          o_DV
);

  // Index widths never drop below one bit, so single-digit or single-bit
  // configurations still elaborate.
  localparam int DIG_W   = (DECIMAL_DIGITS > 1) ? $clog2(DECIMAL_DIGITS) : 1;
  localparam int SHIFT_W = (INPUT_WIDTH > 1) ? $clog2(INPUT_WIDTH) : 1;
  localparam int BCD_W   = 4 * DECIMAL_DIGITS;

  localparam logic [DIG_W-1:0]   LAST_DIGIT = DIG_W'(DECIMAL_DIGITS - 1);
  localparam logic [SHIFT_W-1:0] LAST_SHIFT = SHIFT_W'(INPUT_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CHECK_SHIFT_INDEX,
    ADD,
    CHECK_DIGIT_INDEX,
    BCD_DONE
  } state_t;

  state_t                 state_q,    state_d;
  logic [INPUT_WIDTH-1:0] binary_q,   binary_d;
  logic [BCD_W-1:0]       bcd_q,      bcd_d;
  logic [BCD_W-1:0]       bcdOut_q,   bcdOut_d;
  logic [DIG_W-1:0]       digitIdx_q, digitIdx_d;
  logic [SHIFT_W-1:0]     shiftIdx_q, shiftIdx_d;
  logic                   dv_q,       dv_d;

  // State and datapath registers; reset drops everything back to idle at once.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q    <= IDLE;
      binary_q   <= '0;
      bcd_q      <= '0;
      bcdOut_q   <= '0;
      digitIdx_q <= '0;
      shiftIdx_q <= '0;
      dv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      binary_q   <= binary_d;
      bcd_q      <= bcd_d;
      bcdOut_q   <= bcdOut_d;
      digitIdx_q <= digitIdx_d;
      shiftIdx_q <= shiftIdx_d;
      dv_q       <= dv_d;
    end
  end

  // Next-state and datapath updates for the shift / adjust sequence.
  always_comb begin
    state_d    = state_q;
    binary_d   = binary_q;
    bcd_d      = bcd_q;
    bcdOut_d   = bcdOut_q;
    digitIdx_d = digitIdx_q;
    shiftIdx_d = shiftIdx_q;
    dv_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_Start) begin
          binary_d = i_Binary;
          bcd_d    = '0;
          state_d  = SHIFT;
        end
      end

      SHIFT: begin
        bcd_d    = {bcd_q[BCD_W-2:0], binary_q[INPUT_WIDTH-1]};
        binary_d = binary_q << 1;
        state_d  = CHECK_SHIFT_INDEX;
      end

      CHECK_SHIFT_INDEX: begin
        if (shiftIdx_q == LAST_SHIFT) begin
          shiftIdx_d = '0;
          state_d    = BCD_DONE;
        end else begin
          shiftIdx_d = shiftIdx_q + 1'b1;
          state_d    = ADD;
        end
      end

      ADD: begin
        for (int k = 0; k < DECIMAL_DIGITS; k++) begin
          if (digitIdx_q == DIG_W'(k) && bcd_q[4*k +: 4] > 4'd4) begin
            bcd_d[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
          end
        end
        state_d = CHECK_DIGIT_INDEX;
      end

      CHECK_DIGIT_INDEX: begin
        if (digitIdx_q == LAST_DIGIT) begin
          digitIdx_d = '0;
          state_d    = SHIFT;
        end else begin
          digitIdx_d = digitIdx_q + 1'b1;
          state_d    = ADD;
        end
      end

      BCD_DONE: begin
        bcdOut_d = bcd_q;
        dv_d     = 1'b1;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_BCD = bcdOut_q;
  assign o_DV  = dv_q;

endmodule

// File: tb/tb_binary_to_bcd.sv
// Directed testbench for binary_to_bcd with the default 8-bit / 2-digit setup.
`timescale 1ns/1ps

module tb_binary_to_bcd;

  localparam int LATENCY   = 45;
  localparam int MAX_EDGES = 200;

  logic       i_Clock;
  logic       i_Reset;
  logic [7:0] i_Binary;
  logic       i_Start;
  logic [7:0] o_BCD;
  logic       o_DV;

  int checkCount;
  int errorCount;

  binary_to_bcd #(
    .INPUT_WIDTH   (8),
    .DECIMAL_DIGITS(2)
  ) dut (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Binary(i_Binary),
    .i_Start (i_Start),
    .o_BCD   (o_BCD),
    .o_DV    (o_DV)
  );

  // Free-running 100 MHz clock.
  initial begin
    i_Clock = 1'b0;
    forever #5 i_Clock = ~i_Clock;
  end

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Starts one conversion and waits for its o_DV pulse, then checks the
  // latency and the result. Returns #1 after the edge that raised o_DV, so a
  // caller can start the next conversion in the o_DV cycle.
  task automatic applyStimulus(input logic [7:0] value, input logic [7:0] expBcd,
                               input string tag);
    int  edges;
    logic found;
    i_Binary = value;
    i_Start  = 1'b1;
    @(posedge i_Clock);
    #1;
    i_Start  = 1'b0;
    i_Binary = ~value;
    edges = 0;
    found = 1'b0;
    while (!found && edges < MAX_EDGES) begin
      @(posedge i_Clock);
      #1;
      edges++;
      if (o_DV === 1'b1) found = 1'b1;
    end
    checkOutput({tag, " latency"}, edges, LATENCY);
    checkOutput({tag, " bcd"}, {24'd0, o_BCD}, {24'd0, expBcd});
  endtask

  // Waits a number of edges and counts how many of them show o_DV high.
  task automatic countPulses(input int span, output int pulses);
    pulses = 0;
    for (int n = 0; n < span; n++) begin
      @(posedge i_Clock);
      #1;
      if (o_DV === 1'b1) pulses++;
    end
  endtask

  // Main sequence of directed vectors.
  initial begin
    int pulses;
    int edges;
    logic found;
    checkCount = 0;
    errorCount = 0;
    i_Reset  = 1'b1;
    i_Start  = 1'b0;
    i_Binary = 8'd0;

    #12;
    checkOutput("reset bcd", {24'd0, o_BCD}, 32'h00);
    checkOutput("reset dv", {31'd0, o_DV}, 32'd0);
    @(negedge i_Clock);
    i_Reset = 1'b0;
    @(negedge i_Clock);

    // Basic conversion, then confirm the pulse lasts a single cycle.
    applyStimulus(8'h0C, 8'h12, "conv 12");
    @(posedge i_Clock);
    #1;
    checkOutput("dv one cycle", {31'd0, o_DV}, 32'd0);
    checkOutput("bcd held", {24'd0, o_BCD}, 32'h12);

    applyStimulus(8'd0, 8'h00, "conv 0");
    applyStimulus(8'd99, 8'h99, "conv 99");
    applyStimulus(8'd255, 8'h55, "conv 255");
    countPulses(3, pulses);

    // A start arriving mid-conversion must be ignored entirely.
    i_Binary = 8'd12;
    i_Start  = 1'b1;
    @(posedge i_Clock);
    #1;
    i_Start = 1'b0;
    edges = 0;
    found = 1'b0;
    while (!found && edges < MAX_EDGES) begin
      if (edges == 9) begin
        i_Binary = 8'd34;
        i_Start  = 1'b1;
      end
      @(posedge i_Clock);
      #1;
      edges++;
      if (edges == 10) i_Start = 1'b0;
      if (o_DV === 1'b1) found = 1'b1;
    end
    checkOutput("ignore start latency", edges, LATENCY);
    checkOutput("ignore start bcd", {24'd0, o_BCD}, 32'h12);
    countPulses(60, pulses);
    checkOutput("ignore start no extra dv", pulses, 0);

    // Reset in the middle of a conversion aborts it with no pulse.
    i_Binary = 8'd200;
    i_Start  = 1'b1;
    @(posedge i_Clock);
    #1;
    i_Start = 1'b0;
    for (int n = 0; n < 20; n++) @(posedge i_Clock);
    #1;
    i_Reset = 1'b1;
    #1;
    checkOutput("abort bcd", {24'd0, o_BCD}, 32'h00);
    checkOutput("abort dv", {31'd0, o_DV}, 32'd0);
    @(negedge i_Clock);
    @(negedge i_Clock);
    i_Reset = 1'b0;
    countPulses(60, pulses);
    checkOutput("abort no dv", pulses, 0);
    @(negedge i_Clock);
    applyStimulus(8'd57, 8'h57, "after reset 57");

    // Back-to-back starts issued in the o_DV cycle of the previous result.
    applyStimulus(8'd1, 8'h01, "b2b 1");
    applyStimulus(8'd10, 8'h10, "b2b 10");
    applyStimulus(8'd98, 8'h98, "b2b 98");
    countPulses(5, pulses);
    checkOutput("b2b no extra dv", pulses, 0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
